ddr_cmd_decoder: RTL and testbench

- Front-end command stage of the memory emulator, directly upstream of the per-bank timing FSMs.
- Registers raw DDR4 command/address pins and decodes them into single-cycle command pulses.
- Pulses are one-hot per bank (ACT/RD/RDA/WR/WRA/PR) or global (REF/SRF/PRA/MRW/PD/PDX/CKEH/CKEL), the form the timing FSMs consume.
- Keeps a per-bank open-row table; suppresses and flags protocol-illegal commands so downstream FSMs only see legal traffic.

---
 rtl/ddr_cmd_decoder_pkg.sv | 44 ++++
 rtl/ddr_cmd_decode.sv | 44 ++++
 rtl/ddr_cmd_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ddr_cmd_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_pkg
// Brief    : Shared command enum, error codes and opcode constants for the
//            DDR4 command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_pkg;

   typedef enum logic [3:0] {
      CMD_DES,
      CMD_NOP,
      CMD_ACT,
      CMD_RD,
      CMD_RDA,
      CMD_WR,
      CMD_WRA,
      CMD_PR,
      CMD_PRA,
      CMD_REF,
      CMD_SRF,
      CMD_MRW,
      CMD_ZQC,
      CMD_RSV
   } cmd_e;

   localparam logic [2:0] C_ERR_NONE     = 3'd0;
   localparam logic [2:0] C_ERR_ACT_OPEN = 3'd1;
   localparam logic [2:0] C_ERR_CLOSED   = 3'd2;
   localparam logic [2:0] C_ERR_REF_OPEN = 3'd3;
   localparam logic [2:0] C_ERR_RSV      = 3'd4;

   // {ras_n, cas_n, we_n} when act_n is high
   localparam logic [2:0] C_OP_MRS = 3'b000;
   localparam logic [2:0] C_OP_REF = 3'b001;
   localparam logic [2:0] C_OP_PRE = 3'b010;
   localparam logic [2:0] C_OP_RSV = 3'b011;
   localparam logic [2:0] C_OP_WR  = 3'b100;
   localparam logic [2:0] C_OP_RD  = 3'b101;
   localparam logic [2:0] C_OP_ZQC = 3'b110;
   localparam logic [2:0] C_OP_NOP = 3'b111;

endpackage : ddr_pkg
`default_nettype wire

// File: rtl/ddr_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_decode
// Brief    : Combinational decode of registered DDR4 command pins into a
//            command enum, including CKE-based self-refresh and sleep masking.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_cmd_decode
   import ddr_pkg::*;
(
   input  logic cs_n,
   input  logic act_n,
   input  logic ras_n,
   input  logic cas_n,
   input  logic we_n,
   input  logic a10,
   input  logic cke_q,
   input  logic cke_prev,
   output cmd_e cmd
);

   always_comb begin
      cmd = CMD_DES;
      // With CKE low for two consecutive cycles the device is asleep.
      if (!cs_n && (cke_q || cke_prev)) begin
         if (!act_n) begin
            cmd = CMD_ACT;
         end else begin
            case ({ras_n, cas_n, we_n})
               C_OP_MRS: cmd = CMD_MRW;
               C_OP_REF: cmd = (cke_prev && !cke_q) ? CMD_SRF : CMD_REF;
               C_OP_PRE: cmd = a10 ? CMD_PRA : CMD_PR;
               C_OP_RSV: cmd = CMD_RSV;
               C_OP_WR:  cmd = a10 ? CMD_WRA : CMD_WR;
               C_OP_RD:  cmd = a10 ? CMD_RDA : CMD_RD;
               C_OP_ZQC: cmd = CMD_ZQC;
               default:  cmd = CMD_NOP;
            endcase
         end
      end
   end

endmodule : ddr_cmd_decode
`default_nettype wire

// File: rtl/ddr_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_decoder
// Brief    : Registers DDR4 command pins, tracks open rows per bank, and emits
//            single-cycle legal command pulses for the per-bank timing FSMs.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_cmd_decoder
   import ddr_pkg::*;
#(
   parameter int  BGWIDTH   = 2,
   parameter int  BAWIDTH   = 2,
   parameter int  ADDRWIDTH = 17,
   parameter int  COLWIDTH  = 10,
   localparam int BKWIDTH   = BGWIDTH + BAWIDTH,
   localparam int NB        = 2 ** BKWIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs_n,
   input  logic                 act_n,
   input  logic                 ras_n,
   input  logic                 cas_n,
   input  logic                 we_n,
   input  logic                 cke,
   input  logic [BGWIDTH-1:0]   bg,
   input  logic [BAWIDTH-1:0]   ba,
   input  logic [13:0]          a,
   output logic [NB-1:0]        ACT,
   output logic [NB-1:0]        RD,
   output logic [NB-1:0]        RDA,
   output logic [NB-1:0]        WR,
   output logic [NB-1:0]        WRA,
   output logic [NB-1:0]        PR,
   output logic                 REF,
   output logic                 SRF,
   output logic                 PRA,
   output logic                 MRW,
   output logic                 PD,
   output logic                 PDX,
   output logic                 CKEH,
   output logic                 CKEL,
   output logic [BKWIDTH-1:0]   cmd_bank,
   output logic [ADDRWIDTH-1:0] cmd_row,
   output logic [COLWIDTH-1:0]  cmd_col,
   output logic [NB-1:0]        bank_open,
   output logic                 err,
   output logic [2:0]           err_code
);

   logic                 r_cs_n, r_act_n, r_ras_n, r_cas_n, r_we_n;
   logic                 r_cke, r_cke_prev;
   logic [BGWIDTH-1:0]   r_bg;
   logic [BAWIDTH-1:0]   r_ba;
   logic [13:0]          r_a;
   logic [ADDRWIDTH-1:0] r_row_tbl [NB];

   cmd_e                 w_cmd;
   logic [BKWIDTH-1:0]   w_bank;
   logic [NB-1:0]        w_sel;
   logic                 w_is_open;
   logic [ADDRWIDTH-1:0] w_row;
   logic [COLWIDTH-1:0]  w_col;
   logic                 w_ckel, w_ckeh, w_pd;

   logic [NB-1:0]        w_act, w_rd, w_rda, w_wr, w_wra, w_pr;
   logic                 w_ref, w_srf, w_pra, w_mrw;
   logic                 w_err;
   logic [2:0]           w_err_code;
   logic [NB-1:0]        w_open_nxt;
   logic [BKWIDTH-1:0]   w_bank_nxt;
   logic [ADDRWIDTH-1:0] w_row_nxt;
   logic [COLWIDTH-1:0]  w_col_nxt;
   logic                 w_tbl_we;

   // Reset leaves the pin register holding a deselect with CKE high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_n     <= 1'b1;
         r_act_n    <= 1'b1;
         r_ras_n    <= 1'b1;
         r_cas_n    <= 1'b1;
         r_we_n     <= 1'b1;
         r_cke      <= 1'b1;
         r_cke_prev <= 1'b1;
         r_bg       <= '0;
         r_ba       <= '0;
         r_a        <= '0;
      end else begin
         r_cs_n     <= cs_n;
         r_act_n    <= act_n;
         r_ras_n    <= ras_n;
         r_cas_n    <= cas_n;
         r_we_n     <= we_n;
         r_cke      <= cke;
         r_cke_prev <= r_cke;
         r_bg       <= bg;
         r_ba       <= ba;
         r_a        <= a;
      end
   end

   ddr_cmd_decode u_decode (
      .cs_n     (r_cs_n),
      .act_n    (r_act_n),
      .ras_n    (r_ras_n),
      .cas_n    (r_cas_n),
      .we_n     (r_we_n),
      .a10      (r_a[10]),
      .cke_q    (r_cke),
      .cke_prev (r_cke_prev),
      .cmd      (w_cmd)
   );

   assign w_bank    = {r_bg, r_ba};
   assign w_sel     = NB'(1) << w_bank;
   assign w_is_open = bank_open[w_bank];
   assign w_row     = ADDRWIDTH'({r_ras_n, r_cas_n, r_we_n, r_a});
   assign w_col     = r_a[COLWIDTH-1:0];
   assign w_ckel    = r_cke_prev & ~r_cke;
   assign w_ckeh    = ~r_cke_prev & r_cke;
   assign w_pd      = w_ckel & ((w_cmd == CMD_DES) || (w_cmd == CMD_NOP));

   always_comb begin
      w_act      = '0;
      w_rd       = '0;
      w_rda      = '0;
      w_wr       = '0;
      w_wra      = '0;
      w_pr       = '0;
      w_ref      = 1'b0;
      w_srf      = 1'b0;
      w_pra      = 1'b0;
      w_mrw      = 1'b0;
      w_err      = 1'b0;
      w_err_code = C_ERR_NONE;
      w_open_nxt = bank_open;
      w_bank_nxt = cmd_bank;
      w_row_nxt  = cmd_row;
      w_col_nxt  = cmd_col;
      w_tbl_we   = 1'b0;
      case (w_cmd)
         CMD_ACT: begin
            w_bank_nxt = w_bank;
            if (w_is_open) begin
               w_err      = 1'b1;
               w_err_code = C_ERR_ACT_OPEN;
            end else begin
               w_act      = w_sel;
               w_open_nxt = bank_open | w_sel;
               w_row_nxt  = w_row;
               w_tbl_we   = 1'b1;
            end
         end
         CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: begin
            w_bank_nxt = w_bank;
            w_col_nxt  = w_col;
            if (!w_is_open) begin
               w_err      = 1'b1;
               w_err_code = C_ERR_CLOSED;
            end else begin
               // Column accesses report the row they land in.
               w_row_nxt = r_row_tbl[w_bank];
               case (w_cmd)
                  CMD_RD:  w_rd = w_sel;
                  CMD_WR:  w_wr = w_sel;
                  CMD_RDA: begin
                     w_rda      = w_sel;
                     w_open_nxt = bank_open & ~w_sel;
                  end
                  CMD_WRA: begin
                     w_wra      = w_sel;
                     w_open_nxt = bank_open & ~w_sel;
                  end
                  default: ;
               endcase
            end
         end
         CMD_PR: begin
            w_bank_nxt = w_bank;
            w_pr       = w_sel;
            w_open_nxt = bank_open & ~w_sel;
         end
         CMD_PRA: begin
            w_pra      = 1'b1;
            w_open_nxt = '0;
         end
         CMD_REF, CMD_SRF: begin
            if (|bank_open) begin
               w_err      = 1'b1;
               w_err_code = C_ERR_REF_OPEN;
            end else if (w_cmd == CMD_SRF) begin
               w_srf = 1'b1;
            end else begin
               w_ref = 1'b1;
            end
         end
         CMD_MRW: w_mrw = 1'b1;
         CMD_RSV: begin
            w_err      = 1'b1;
            w_err_code = C_ERR_RSV;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ACT       <= '0;
         RD        <= '0;
         RDA       <= '0;
         WR        <= '0;
         WRA       <= '0;
         PR        <= '0;
         REF       <= 1'b0;
         SRF       <= 1'b0;
         PRA       <= 1'b0;
         MRW       <= 1'b0;
         PD        <= 1'b0;
         PDX       <= 1'b0;
         CKEH      <= 1'b0;
         CKEL      <= 1'b0;
         cmd_bank  <= '0;
         cmd_row   <= '0;
         cmd_col   <= '0;
         bank_open <= '0;
         err       <= 1'b0;
         err_code  <= C_ERR_NONE;
      end else begin
         ACT       <= w_act;
         RD        <= w_rd;
         RDA       <= w_rda;
         WR        <= w_wr;
         WRA       <= w_wra;
         PR        <= w_pr;
         REF       <= w_ref;
         SRF       <= w_srf;
         PRA       <= w_pra;
         MRW       <= w_mrw;
         PD        <= w_pd;
         PDX       <= w_ckeh;
         CKEH      <= w_ckeh;
         CKEL      <= w_ckel;
         cmd_bank  <= w_bank_nxt;
         cmd_row   <= w_row_nxt;
         cmd_col   <= w_col_nxt;
         bank_open <= w_open_nxt;
         err       <= w_err;
         err_code  <= w_err_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            r_row_tbl[i] <= '0;
         end
      end else if (w_tbl_we) begin
         r_row_tbl[w_bank] <= w_row;
      end
   end

endmodule : ddr_cmd_decoder
`default_nettype wire

// File: tb/tb_ddr_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_cmd_decoder
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_cmd_decoder;

   typedef struct packed {
      logic        cs_n, act_n, ras_n, cas_n, we_n, cke;
      logic [1:0]  bg, ba;
      logic [13:0] a;
   } pins_t;

   typedef struct packed {
      logic [15:0] act, rd, rda, wr, wra, pr;
      logic        ref_, srf, pra, mrw, pd, pdx, ckeh, ckel;
      logic [3:0]  bank;
      logic [16:0] row;
      logic [9:0]  col;
      logic [15:0] open;
      logic        err;
      logic [2:0]  code;
   } outs_t;

   logic  clk = 1'b0;
   always #5 clk = ~clk;

   pins_t cur_pins;
   logic  cur_rst;

   logic [15:0] ACT, RD, RDA, WR, WRA, PR, bank_open;
   logic        REF, SRF, PRA, MRW, PD, PDX, CKEH, CKEL, err;
   logic [3:0]  cmd_bank;
   logic [16:0] cmd_row;
   logic [9:0]  cmd_col;
   logic [2:0]  err_code;
   outs_t       dut_o;

   ddr_cmd_decoder dut (
      .clk(clk), .rst(cur_rst),
      .cs_n(cur_pins.cs_n), .act_n(cur_pins.act_n), .ras_n(cur_pins.ras_n),
      .cas_n(cur_pins.cas_n), .we_n(cur_pins.we_n), .cke(cur_pins.cke),
      .bg(cur_pins.bg), .ba(cur_pins.ba), .a(cur_pins.a),
      .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR),
      .REF(REF), .SRF(SRF), .PRA(PRA), .MRW(MRW), .PD(PD), .PDX(PDX),
      .CKEH(CKEH), .CKEL(CKEL), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
      .cmd_col(cmd_col), .bank_open(bank_open), .err(err), .err_code(err_code)
   );

   assign dut_o = {ACT, RD, RDA, WR, WRA, PR, REF, SRF, PRA, MRW, PD, PDX, CKEH, CKEL,
                   cmd_bank, cmd_row, cmd_col, bank_open, err, err_code};

   // Reference model state: one pin-register stage plus the visible outputs
   pins_t       m_p1;
   logic        m_ckeprev;
   outs_t       m_out;
   logic [16:0] m_rowtbl [16];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic pins_t idle();
      pins_t p;
      p = '0;
      p.cs_n = 1'b1; p.act_n = 1'b1; p.ras_n = 1'b1; p.cas_n = 1'b1; p.we_n = 1'b1;
      p.cke = 1'b1;
      return p;
   endfunction

   function automatic pins_t p_op(input logic [2:0] op, input logic [3:0] bank,
                                  input logic a10, input logic [9:0] col, input logic cke);
      pins_t p;
      p = idle();
      p.cs_n = 1'b0;
      {p.ras_n, p.cas_n, p.we_n} = op;
      {p.bg, p.ba} = bank;
      p.a[10] = a10;
      p.a[9:0] = col;
      p.cke = cke;
      return p;
   endfunction

   function automatic pins_t p_act(input logic [3:0] bank, input logic [16:0] row, input logic cke);
      pins_t p;
      p = idle();
      p.cs_n = 1'b0;
      p.act_n = 1'b0;
      {p.ras_n, p.cas_n, p.we_n, p.a} = row;
      {p.bg, p.ba} = bank;
      p.cke = cke;
      return p;
   endfunction

   function automatic pins_t nop(input logic cke);
      return p_op(3'b111, 4'd0, 1'b0, 10'd0, cke);
   endfunction

   task automatic model_step(input logic r, input pins_t pin);
      outs_t n;
      int    b, op;
      bit    fall, rise, live, quiet;
      if (r) begin
         m_p1 = idle();
         m_ckeprev = 1'b1;
         m_out = '0;
         for (int i = 0; i < 16; i++) m_rowtbl[i] = '0;
      end else begin
         n = m_out;
         n.act = '0; n.rd = '0; n.rda = '0; n.wr = '0; n.wra = '0; n.pr = '0;
         n.ref_ = 0; n.srf = 0; n.pra = 0; n.mrw = 0; n.err = 0; n.code = 3'd0;
         b     = int'({m_p1.bg, m_p1.ba});
         op    = int'({m_p1.ras_n, m_p1.cas_n, m_p1.we_n});
         fall  = m_ckeprev && !m_p1.cke;
         rise  = !m_ckeprev && m_p1.cke;
         live  = !m_p1.cs_n && (m_ckeprev || m_p1.cke);
         quiet = m_p1.cs_n || (m_p1.act_n && op == 7);
         n.ckel = fall; n.pd = fall && quiet; n.ckeh = rise; n.pdx = rise;
         if (live) begin
            if (!m_p1.act_n) begin
               n.bank = 4'(b);
               if (m_out.open[b]) begin
                  n.err = 1; n.code = 3'd1;
               end else begin
                  m_rowtbl[b] = {m_p1.ras_n, m_p1.cas_n, m_p1.we_n, m_p1.a};
                  n.act[b] = 1; n.open[b] = 1; n.row = m_rowtbl[b];
               end
            end else if (op == 4 || op == 5) begin
               n.bank = 4'(b);
               n.col  = m_p1.a[9:0];
               if (!m_out.open[b]) begin
                  n.err = 1; n.code = 3'd2;
               end else begin
                  n.row = m_rowtbl[b];
                  if (op == 5) begin
                     if (m_p1.a[10]) n.rda[b] = 1; else n.rd[b] = 1;
                  end else begin
                     if (m_p1.a[10]) n.wra[b] = 1; else n.wr[b] = 1;
                  end
                  if (m_p1.a[10]) n.open[b] = 0;
               end
            end else if (op == 2) begin
               if (m_p1.a[10]) begin
                  n.pra = 1; n.open = '0;
               end else begin
                  n.bank = 4'(b); n.pr[b] = 1; n.open[b] = 0;
               end
            end else if (op == 1) begin
               if (m_out.open != 16'd0) begin
                  n.err = 1; n.code = 3'd3;
               end else if (fall) n.srf = 1;
               else n.ref_ = 1;
            end else if (op == 0) begin
               n.mrw = 1;
            end else if (op == 3) begin
               n.err = 1; n.code = 3'd4;
            end
         end
         m_ckeprev = m_p1.cke;
         m_p1 = pin;
         m_out = n;
      end
   endtask

   // One clock: model the edge, drive the next pins, compare at the falling edge
   task automatic tick(input pins_t p, input logic r);
      @(posedge clk);
      model_step(cur_rst, cur_pins);
      #1;
      cur_pins = p;
      cur_rst  = r;
      @(negedge clk);
      cyc++;
      total++;
      if (dut_o !== m_out) begin
         bad++;
         $display("FAIL cycle%0d outputs dut=%h model=%h", cyc, dut_o, m_out);
      end
   endtask

   task automatic lit(input string nm, input logic [31:0] dv, input logic [31:0] mv,
                      input logic [31:0] ev);
      total++;
      if (dv !== ev) begin
         bad++;
         $display("FAIL %s dut=%0h want=%0h", nm, dv, ev);
      end
      total++;
      if (mv !== ev) begin
         bad++;
         $display("FAIL %s model=%0h want=%0h", nm, mv, ev);
      end
   endtask

   initial begin
      logic  rc;
      pins_t p;
      int    r;
      logic [3:0] bk;

      cur_pins = idle();
      cur_rst  = 1'b1;
      m_p1 = idle(); m_ckeprev = 1'b1; m_out = '0;
      for (int i = 0; i < 16; i++) m_rowtbl[i] = '0;

      repeat (3) tick(idle(), 1'b1);
      tick(nop(1'b1), 1'b0);
      lit("reset_any", 32'(|dut_o), 32'(|m_out), 32'd0);

      // ACT bank 6 then RD
      tick(p_act(4'd6, 17'h1ABCD, 1'b1), 1'b0);
      tick(p_op(3'b101, 4'd6, 1'b0, 10'h040, 1'b1), 1'b0);
      tick(nop(1'b1), 1'b0);
      lit("act6", 32'(ACT), 32'(m_out.act), 32'h0040);
      lit("act6_row", 32'(cmd_row), 32'(m_out.row), 32'h1ABCD);
      tick(nop(1'b1), 1'b0);
      lit("rd6", 32'(RD), 32'(m_out.rd), 32'h0040);
      lit("rd6_col", 32'(cmd_col), 32'(m_out.col), 32'h040);
      lit("rd6_open", 32'(bank_open), 32'(m_out.open), 32'h0040);

      // RDA closes bank 6, WR then fails
      tick(p_op(3'b101, 4'd6, 1'b1, 10'h041, 1'b1), 1'b0);
      tick(p_op(3'b100, 4'd6, 1'b0, 10'h042, 1'b1), 1'b0);
      tick(nop(1'b1), 1'b0);
      lit("rda6", 32'(RDA), 32'(m_out.rda), 32'h0040);
      tick(nop(1'b1), 1'b0);
      lit("wr_closed_open", 32'(bank_open), 32'(m_out.open), 32'h0);
      lit("wr_closed_code", 32'({err, err_code}), 32'({m_out.err, m_out.code}), 32'h0A);
      lit("wr_closed_pulse", 32'(WR), 32'(m_out.wr), 32'h0);
      lit("wr_closed_col", 32'(cmd_col), 32'(m_out.col), 32'h042);

      // Double ACT to bank 3, then PRA
      tick(p_act(4'd3, 17'h00111, 1'b1), 1'b0);
      tick(p_act(4'd3, 17'h00222, 1'b1), 1'b0);
      tick(p_op(3'b010, 4'd0, 1'b1, 10'd0, 1'b1), 1'b0);
      lit("act3", 32'(ACT), 32'(m_out.act), 32'h0008);
      tick(nop(1'b1), 1'b0);
      lit("act3_again", 32'({err, err_code, ACT}), 32'({m_out.err, m_out.code, m_out.act}), 32'h90000);
      lit("act3_row", 32'(cmd_row), 32'(m_out.row), 32'h00111);
      tick(nop(1'b1), 1'b0);
      lit("pra", 32'({PRA, bank_open}), 32'({m_out.pra, m_out.open}), 32'h10000);

      // REF with bank 0 open, PR, REF
      tick(p_act(4'd0, 17'h00005, 1'b1), 1'b0);
      tick(p_op(3'b001, 4'd0, 1'b0, 10'd0, 1'b1), 1'b0);
      tick(p_op(3'b010, 4'd0, 1'b0, 10'd0, 1'b1), 1'b0);
      lit("act0_open", 32'(bank_open), 32'(m_out.open), 32'h0001);
      tick(p_op(3'b001, 4'd0, 1'b0, 10'd0, 1'b1), 1'b0);
      lit("ref_open", 32'({REF, err, err_code}), 32'({m_out.ref_, m_out.err, m_out.code}), 32'h0B);
      tick(nop(1'b1), 1'b0);
      lit("pr0", 32'(PR), 32'(m_out.pr), 32'h0001);
      tick(nop(1'b1), 1'b0);
      lit("ref_ok", 32'({REF, SRF, err}), 32'({m_out.ref_, m_out.srf, m_out.err}), 32'h4);

      // Self refresh entry and exit
      tick(p_op(3'b001, 4'd0, 1'b0, 10'd0, 1'b0), 1'b0);
      tick(nop(1'b0), 1'b0);
      tick(nop(1'b0), 1'b0);
      lit("srf", 32'({REF, SRF, CKEL, PD}), 32'({m_out.ref_, m_out.srf, m_out.ckel, m_out.pd}), 32'h6);
      tick(nop(1'b1), 1'b0);
      tick(nop(1'b1), 1'b0);
      tick(nop(1'b1), 1'b0);
      lit("cke_rise", 32'({CKEH, PDX, CKEL}), 32'({m_out.ckeh, m_out.pdx, m_out.ckel}), 32'h6);

      // Reset while ACT sits in the pin register
      tick(p_act(4'd2, 17'h00ABC, 1'b1), 1'b0);
      tick(nop(1'b1), 1'b1);
      tick(nop(1'b1), 1'b0);
      lit("rst_all", 32'(|dut_o), 32'(|m_out), 32'd0);
      tick(nop(1'b1), 1'b0);
      lit("rst_no_act", 32'({ACT, bank_open}), 32'({m_out.act, m_out.open}), 32'd0);

      // Random traffic on eight banks with occasional CKE toggles and resets
      rc = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < (rc ? 4 : 30)) rc = ~rc;
         r  = int'($urandom_range(0, 99));
         bk = 4'($urandom_range(0, 7));
         if (r < 8) begin
            p = idle();
            p.cke = rc;
         end else if (r < 30) begin
            p = p_act(bk, 17'($urandom), rc);
         end else begin
            p = p_op(3'($urandom_range(0, 7)), bk, 1'($urandom_range(0, 1)), 10'($urandom), rc);
         end
         tick(p, ($urandom_range(0, 199) == 0));
      end
      repeat (3) tick(nop(1'b1), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ddr_cmd_decoder
`default_nettype wire
